// File: rtl/mul_seq_pkg.sv
//==============================================================================
// mul_seq_pkg : shared types and sizing helpers for the sequential multiplier
// Rev 1.0
//==============================================================================
`default_nettype none

package mul_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_SIGN = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int DEF_WIDTH = 6;
    localparam int DEF_RES_W = 2 * DEF_WIDTH;

    function automatic int cnt_width(input int width);
        return $clog2(width - 1);
    endfunction

    function automatic int res_width(input int width);
        return 2 * width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mul_seq_if.sv
//==============================================================================
// mul_seq_if : operand and result handshakes of the sequential multiplier
// Rev 1.0
//==============================================================================
`default_nettype none

interface mul_seq_if
    import mul_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic                          in_valid;
    logic                          in_ready;
    logic [WIDTH-1:0]              a;
    logic [WIDTH-1:0]              b;
    logic                          out_valid;
    logic                          out_ready;
    logic [res_width(WIDTH)-1:0]   out;
    logic                          busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, out, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, out, busy
    );
endinterface

`default_nettype wire

// File: rtl/mul_seq_dp.sv
//==============================================================================
// mul_seq_dp : operand/sign registers, shift-add accumulator and final negate
// Rev 1.0
//==============================================================================
`default_nettype none

module mul_seq_dp
    import mul_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  wire logic                          clk,
    input  wire logic                          rst_n,
    input  wire logic                          load,
    input  wire logic                          step,
    input  wire logic                          finish,
    input  wire logic [WIDTH-1:0]              a,
    input  wire logic [WIDTH-1:0]              b,
    input  wire logic [cnt_width(WIDTH)-1:0]   cnt,
    output logic      [res_width(WIDTH)-1:0]   out
);
    localparam int MAG_W = WIDTH - 1;
    localparam int ACC_W = 2 * WIDTH - 2;
    localparam int RES_W = res_width(WIDTH);

    logic [MAG_W-1:0] r_mag_a;
    logic [MAG_W-1:0] r_mag_b;
    logic             r_sgn;
    logic [ACC_W-1:0] r_acc;

    logic [ACC_W-1:0] w_addend;
    logic [RES_W-1:0] w_zext;
    logic [RES_W-1:0] w_result;

    assign w_addend = {{MAG_W{1'b0}}, r_mag_a} << cnt;
    assign w_zext   = {2'b00, r_acc};
    // A zero magnitude stays zero regardless of sign, so -0 never appears.
    assign w_result = (r_sgn && (r_acc != '0)) ? (~w_zext + 1'b1) : w_zext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mag_a <= '0;
            r_mag_b <= '0;
            r_sgn   <= 1'b0;
            r_acc   <= '0;
            out     <= '0;
        end else begin
            if (load) begin
                r_mag_a <= a[WIDTH-2:0];
                r_mag_b <= b[WIDTH-2:0];
                r_sgn   <= a[WIDTH-1] ^ b[WIDTH-1];
                r_acc   <= '0;
            end else if (step && r_mag_b[cnt]) begin
                r_acc   <= r_acc + w_addend;
            end
            if (finish) begin
                out     <= w_result;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mul_seq_ctrl.sv
//==============================================================================
// mul_seq_ctrl : sequential sign-magnitude multiplier, FSM and bit counter
// Rev 1.0
//==============================================================================
`default_nettype none

module mul_seq_ctrl
    import mul_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    mul_seq_if.slave    bus
);
    localparam int                CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]     C_LAST   = CW'(WIDTH - 2);

    state_t         r_state;
    state_t         w_state_nx;
    logic [CW-1:0]  r_cnt;
    logic           r_out_valid;
    logic           w_load;
    logic           w_step;
    logic           w_finish;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_load     = 1'b0;
        w_step     = 1'b0;
        w_finish   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    w_load     = 1'b1;
                    w_state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                w_step = 1'b1;
                if (r_cnt == C_LAST) begin
                    w_state_nx = ST_SIGN;
                end
            end
            ST_SIGN: begin
                w_finish   = 1'b1;
                w_state_nx = ST_DONE;
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    w_state_nx = ST_IDLE;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_load) begin
                r_cnt <= '0;
            end else if (w_step) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_finish) begin
                r_out_valid <= 1'b1;
            end else if ((r_state == ST_DONE) && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.busy      = (r_state == ST_RUN) || (r_state == ST_SIGN);
    assign bus.out_valid = r_out_valid;

    mul_seq_dp #(
        .WIDTH  (WIDTH)
    ) u_dp (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (w_load),
        .step   (w_step),
        .finish (w_finish),
        .a      (bus.a),
        .b      (bus.b),
        .cnt    (r_cnt),
        .out    (bus.out)
    );

endmodule

`default_nettype wire
